// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared widths, FSM state types and timer sizing for the UART command controller
package uart_cmd_pkg;
    localparam int CMD_W = 16;
    localparam int BYTE_W = 8;
    typedef enum logic {WAIT_HI, WAIT_LO} rx_state_t;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;
    function automatic int tmr_w(input int cyc);
        return $clog2(cyc);
    endfunction
endpackage

// File: rtl/uart_resp_queue.sv
// uart_resp_queue: transmitter sequencer with one pending response slot behind the byte in flight
module uart_resp_queue
    import uart_cmd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              send_resp,
    input  logic [BYTE_W-1:0] resp,
    input  logic              tx_done,
    output logic              trmt,
    output logic [BYTE_W-1:0] tx_data,
    output logic              resp_drop
);
    tx_state_t         tx_state;
    logic              pend_v;
    logic [BYTE_W-1:0] pend;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            pend_v <= 1'b0;
            pend <= '0;
            trmt <= 1'b0;
            tx_data <= '0;
            resp_drop <= 1'b0;
        end else begin
            trmt <= 1'b0;
            resp_drop <= 1'b0;
            case (tx_state)
                TX_IDLE: if (send_resp) begin
                    tx_data <= resp;
                    trmt <= 1'b1;
                    tx_state <= TX_BUSY;
                end
                TX_BUSY: begin
                    // a request arriving while the slot is occupied is dropped, even if tx_done frees it this cycle
                    if (send_resp && pend_v) resp_drop <= 1'b1;
                    if (tx_done && pend_v) begin
                        tx_data <= pend;
                        trmt <= 1'b1;
                        pend_v <= 1'b0;
                    end else if (tx_done && send_resp) begin
                        tx_data <= resp;
                        trmt <= 1'b1;
                    end else if (tx_done) begin
                        tx_state <= TX_IDLE;
                    end else if (send_resp && !pend_v) begin
                        pend <= resp;
                        pend_v <= 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: assembles two received bytes into a 16-bit command and sequences single-byte responses.
// Define UART_CMD_TIMEOUT_EN to compile in the inter-byte timeout that drops a stale high byte.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              clr_rx_rdy,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_rdy,
    input  logic              clr_cmd_rdy,
    output logic              overrun,
    input  logic              send_resp,
    input  logic [BYTE_W-1:0] resp,
    output logic              trmt,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_done,
    output logic              resp_drop
);
    rx_state_t         rx_state;
    logic [BYTE_W-1:0] hi;
    logic              accept;
    logic              expire;
    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYC out of range 2..65535");
    end
    // the clear pulse blocks re-capture while the receiver's flag is still falling
    assign accept = rx_rdy & ~clr_rx_rdy;
`ifdef UART_CMD_TIMEOUT_EN
    localparam int TW = tmr_w(TIMEOUT_CYC);
    logic [TW-1:0] tmr;
    assign expire = (rx_state == WAIT_LO) && (tmr == TW'(TIMEOUT_CYC - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmr <= '0;
        else tmr <= (rx_state == WAIT_LO && !accept && !expire) ? tmr + 1'b1 : '0;
    end
`else
    assign expire = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= WAIT_HI;
            hi <= '0;
            clr_rx_rdy <= 1'b0;
            cmd <= '0;
            cmd_rdy <= 1'b0;
            overrun <= 1'b0;
        end else begin
            clr_rx_rdy <= accept;
            if (clr_cmd_rdy) cmd_rdy <= 1'b0;
            case (rx_state)
                WAIT_HI: if (accept) begin
                    hi <= rx_data;
                    rx_state <= WAIT_LO;
                end
                WAIT_LO: if (accept) begin
                    cmd <= {hi, rx_data};
                    cmd_rdy <= 1'b1;
                    overrun <= overrun | cmd_rdy;
                    rx_state <= WAIT_HI;
                end else if (expire) begin
                    rx_state <= WAIT_HI;
                end
                default: rx_state <= WAIT_HI;
            endcase
        end
    end
    uart_resp_queue u_resp_queue (
        .clk       (clk),
        .rst       (rst),
        .send_resp (send_resp),
        .resp      (resp),
        .tx_done   (tx_done),
        .trmt      (trmt),
        .tx_data   (tx_data),
        .resp_drop (resp_drop)
    );
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed stimulus checked every cycle against a queue-based behavioural model
module tb_uart_cmd_ctrl;
    localparam int TO = 100;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        overrun;
    logic        send_resp = 1'b0;
    logic [7:0]  resp = '0;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic        resp_drop;
    int n_chk = 0;
    int n_fail = 0;
    int clr_cnt = 0;
    int drop_cnt = 0;
    int c0;
    logic [7:0] tx_seen[$];
    logic        m_clr = 1'b0, m_cmd_rdy = 1'b0, m_ovr = 1'b0, m_trmt = 1'b0, m_drop = 1'b0;
    logic [15:0] m_cmd = '0;
    logic [7:0]  m_tx = '0;
    logic [7:0]  hi = '0;
    bit          have_hi = 1'b0;
    int          cyc = 0;
    int          hi_cyc = 0;
    logic [7:0]  q[$];

    uart_cmd_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .overrun     (overrun),
        .send_resp   (send_resp),
        .resp        (resp),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .resp_drop   (resp_drop)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // receiver model: flag stays up one cycle past the clear pulse, as a real receiver's would
    task automatic send_byte(input logic [7:0] b, input bit pulse_clr = 1'b0);
        int n = 0;
        rx_data = b;
        rx_rdy = 1'b1;
        clr_cmd_rdy = pulse_clr;
        step();
        clr_cmd_rdy = 1'b0;
        while (!clr_rx_rdy && n < 20) begin
            step();
            n++;
        end
        if (!clr_rx_rdy) begin
            n_chk++;
            n_fail++;
            $display("FAIL rx_handshake: clr_rx_rdy stayed %b for byte %h, required 1", clr_rx_rdy, b);
        end
        step();
        rx_rdy = 1'b0;
        step();
    endtask

    task automatic pulse_done(input bit with_resp = 1'b0, input logic [7:0] r = 8'h00);
        tx_done = 1'b1;
        send_resp = with_resp;
        resp = r;
        step();
        tx_done = 1'b0;
        send_resp = 1'b0;
    endtask

    // behavioural model: pending byte count, response FIFO of depth two, timestamped high byte
    initial begin : model
        bit acc, done, drop, launch;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_clr = 0; m_cmd = 0; m_cmd_rdy = 0; m_ovr = 0;
                m_trmt = 0; m_tx = 0; m_drop = 0;
                have_hi = 0;
                q.delete();
            end else begin
                cyc++;
                acc = rx_rdy && !m_clr;
`ifdef UART_CMD_TIMEOUT_EN
                if (have_hi && !acc && cyc - hi_cyc >= TO) have_hi = 0;
`endif
                done = acc && have_hi;
                if (done) begin
                    m_ovr = m_ovr | m_cmd_rdy;
                    m_cmd = {hi, rx_data};
                end
                m_cmd_rdy = done || (m_cmd_rdy && !clr_cmd_rdy);
                if (acc && !have_hi) begin
                    hi = rx_data;
                    hi_cyc = cyc;
                end
                if (acc) have_hi = !have_hi;
                m_clr = acc;
                drop = send_resp && q.size() == 2;
                launch = 0;
                if (tx_done && q.size() > 0) begin
                    void'(q.pop_front());
                    launch = q.size() > 0;
                end
                if (send_resp && !drop) begin
                    q.push_back(resp);
                    if (q.size() == 1) launch = 1;
                end
                m_drop = drop;
                m_trmt = launch;
                if (launch) m_tx = q[0];
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("clr_rx_rdy", {31'd0, clr_rx_rdy}, {31'd0, m_clr});
        chk("cmd", {16'd0, cmd}, {16'd0, m_cmd});
        chk("cmd_rdy", {31'd0, cmd_rdy}, {31'd0, m_cmd_rdy});
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        chk("trmt", {31'd0, trmt}, {31'd0, m_trmt});
        chk("tx_data", {24'd0, tx_data}, {24'd0, m_tx});
        chk("resp_drop", {31'd0, resp_drop}, {31'd0, m_drop});
        if (clr_rx_rdy) clr_cnt++;
        if (resp_drop) drop_cnt++;
        if (trmt) tx_seen.push_back(tx_data);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        chk("rst_cmd", {16'd0, cmd}, 32'h0);
        chk("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        // basic two-byte command
        c0 = clr_cnt;
        send_byte(8'hA5);
        send_byte(8'h3C);
        chk("two_clr_pulses", clr_cnt - c0, 2);
        chk("cmd_A53C", {16'd0, cmd}, 32'hA53C);
        chk("cmd_rdy_set", {31'd0, cmd_rdy}, 32'h1);
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        chk("cmd_rdy_cleared", {31'd0, cmd_rdy}, 32'h0);
        // flag held across the clear pulse yields a single accept
        c0 = clr_cnt;
        send_byte(8'h55);
        chk("single_clr_on_hold", clr_cnt - c0, 1);
        send_byte(8'h66);
        chk("cmd_5566", {16'd0, cmd}, 32'h5566);
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        // overrun with simultaneous clear: set wins
        send_byte(8'h11);
        send_byte(8'h11);
        chk("overrun_clear_before", {31'd0, overrun}, 32'h0);
        send_byte(8'h22);
        send_byte(8'h33, 1'b1);
        chk("cmd_2233", {16'd0, cmd}, 32'h2233);
        chk("overrun_set", {31'd0, overrun}, 32'h1);
        chk("cmd_rdy_set_wins", {31'd0, cmd_rdy}, 32'h1);
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        // inter-byte timeout
        send_byte(8'h77);
        repeat (TO) step();
        send_byte(8'h12);
        send_byte(8'h34);
`ifdef UART_CMD_TIMEOUT_EN
        chk("timeout_cmd", {16'd0, cmd}, 32'h1234);
`else
        chk("no_timeout_cmd", {16'd0, cmd}, 32'h7712);
        send_byte(8'h00);
`endif
        // response queueing
        send_resp = 1'b1;
        resp = 8'h06;
        step();
        chk("trmt_first", {31'd0, trmt}, 32'h1);
        resp = 8'h15;
        step();
        resp = 8'h21;
        step();
        send_resp = 1'b0;
        chk("resp_drop_pulse", {31'd0, resp_drop}, 32'h1);
        repeat (3) step();
        chk("drop_count", drop_cnt, 1);
        chk("tx_seen_one", tx_seen.size(), 1);
        chk("tx_data_held_06", {24'd0, tx_data}, 32'h06);
        pulse_done();
        chk("trmt_after_done", {31'd0, trmt}, 32'h1);
        chk("tx_data_15", {24'd0, tx_data}, 32'h15);
        repeat (2) step();
        pulse_done(1'b1, 8'h42);
        chk("trmt_done_and_send", {31'd0, trmt}, 32'h1);
        chk("tx_data_42", {24'd0, tx_data}, 32'h42);
        repeat (2) step();
        pulse_done();
        repeat (2) step();
        chk("tx_seen_three", tx_seen.size(), 3);
        if (tx_seen.size() == 3) begin
            chk("tx_seq0", {24'd0, tx_seen[0]}, 32'h06);
            chk("tx_seq1", {24'd0, tx_seen[1]}, 32'h15);
            chk("tx_seq2", {24'd0, tx_seen[2]}, 32'h42);
        end
        // asynchronous reset while mid-command and transmitting
        send_byte(8'hAB);
        send_resp = 1'b1;
        resp = 8'h99;
        step();
        send_resp = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cmd", {16'd0, cmd}, 32'h0);
        chk("arst_cmd_rdy", {31'd0, cmd_rdy}, 32'h0);
        chk("arst_overrun", {31'd0, overrun}, 32'h0);
        chk("arst_tx_data", {24'd0, tx_data}, 32'h0);
        chk("arst_trmt", {31'd0, trmt}, 32'h0);
        chk("arst_clr", {31'd0, clr_rx_rdy}, 32'h0);
        chk("arst_drop", {31'd0, resp_drop}, 32'h0);
        repeat (2) step();
        @(negedge clk);
        rst = 1'b0;
        step();
        send_byte(8'hBE);
        send_byte(8'hEF);
        chk("cmd_BEEF", {16'd0, cmd}, 32'hBEEF);
        chk("overrun_after_rst", {31'd0, overrun}, 32'h0);
        send_resp = 1'b1;
        resp = 8'h5A;
        step();
        send_resp = 1'b0;
        chk("trmt_after_rst", {31'd0, trmt}, 32'h1);
        chk("tx_data_5A", {24'd0, tx_data}, 32'h5A);
        repeat (2) step();
        pulse_done();
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
